// File: rtl/money_field_if.sv
// Bundle of the money field's game-side inputs and its collect/render outputs.
// The game/video logic drives through master; the money field consumes through slave.
interface money_field_if #(
    parameter int NUM_SLOTS = 4
) ();
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic                 SpawnEnable;
    logic                 P1Full;
    logic                 P2Full;
    logic [2:0]           Random;
    logic [4:0]           P1HbOffset;
    logic [4:0]           P2HbOffset;
    logic [9:0]           P1X;
    logic [9:0]           P1Y;
    logic [9:0]           P2X;
    logic [9:0]           P2Y;
    logic [9:0]           DrawX;
    logic [9:0]           DrawY;
    logic [1:0]           P1Collect;
    logic [1:0]           P2Collect;
    logic [SLOT_W-1:0]    P1Slot;
    logic [SLOT_W-1:0]    P2Slot;
    logic [NUM_SLOTS-1:0] ActiveMask;
    logic                 MoneyPixel;
    logic [1:0]           Tile;
    logic [4:0]           PixelX;
    logic [4:0]           PixelY;

    modport slave (
        input  SpawnEnable, P1Full, P2Full, Random, P1HbOffset, P2HbOffset,
        input  P1X, P1Y, P2X, P2Y, DrawX, DrawY,
        output P1Collect, P2Collect, P1Slot, P2Slot, ActiveMask,
        output MoneyPixel, Tile, PixelX, PixelY
    );

    modport master (
        output SpawnEnable, P1Full, P2Full, Random, P1HbOffset, P2HbOffset,
        output P1X, P1Y, P2X, P2Y, DrawX, DrawY,
        input  P1Collect, P2Collect, P1Slot, P2Slot, ActiveMask,
        input  MoneyPixel, Tile, PixelX, PixelY
    );
endinterface

// File: rtl/money_field.sv
// Multi-slot cash bag manager: per-slot spawn/cooldown FSMs, two-player grab
// arbitration with registered collect pulses, and the combinational sprite lookup.
module money_field #(
    parameter int         NUM_SLOTS    = 4,
    parameter logic [9:0] SLOT_X0      = 10'd64,
    parameter logic [9:0] SLOT_PITCH   = 10'd128,
    parameter logic [9:0] SPAWN_Y      = 10'd436,
    parameter logic [9:0] MONEY_W      = 10'd18,
    parameter logic [9:0] MONEY_H      = 10'd18,
    parameter int         BASE_RESPAWN = 595,
    parameter int         DELAY_STEP   = 60,
    parameter int         TIMER_W      = 11,
    parameter int         GOLD_EN      = 1
) (
    input  logic          FrameClk,
    input  logic          Reset,
    money_field_if.slave  bus
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_ACTIVE = 2'd1,
        SLOT_COOL   = 2'd2
    } slot_state_e;

    // Player hitboxes are 16x16 starting 16 rows below the sprite origin.
    logic [9:0] p1_hx, p1_hy, p2_hx, p2_hy;
    assign p1_hx = bus.P1X + {5'd0, bus.P1HbOffset};
    assign p1_hy = bus.P1Y + 10'd16;
    assign p2_hx = bus.P2X + {5'd0, bus.P2HbOffset};
    assign p2_hy = bus.P2Y + 10'd16;

    logic [NUM_SLOTS-1:0] active;
    logic [NUM_SLOTS-1:0] p1_ovl;
    logic [NUM_SLOTS-1:0] p2_ovl;
    logic [NUM_SLOTS-1:0] pix_hit;
    logic [NUM_SLOTS-1:0] granted;
    logic [1:0]           slot_tier [NUM_SLOTS];
    logic [4:0]           slot_px   [NUM_SLOTS];
    logic [4:0]           slot_py   [NUM_SLOTS];

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
        localparam logic [9:0] SLOT_X  = 10'(SLOT_X0 + gi * SLOT_PITCH);
        localparam logic [9:0] SLOT_XR = SLOT_X + MONEY_W;
        localparam logic [9:0] SLOT_YB = SPAWN_Y + MONEY_H;
        localparam logic [2:0] IDX3    = 3'(gi);

        slot_state_e          state_q, state_d;
        logic [1:0]           tier_q, tier_d;
        logic [2:0]           delay_q, delay_d;
        logic [TIMER_W-1:0]   timer_q, timer_d;
        logic [2:0]           roll_r;
        logic [1:0]           roll_tier;
        logic [TIMER_W-1:0]   cool_last;
        logic                 is_active;

        // Each slot sees its own scrambled view of the shared random bits.
        assign roll_r    = bus.Random ^ IDX3;
        assign roll_tier = ((GOLD_EN != 0) && (roll_r[1:0] == 2'b11)) ? 2'd3
                                                                     : {1'b0, roll_r[0]} + 2'd1;
        assign cool_last = TIMER_W'(BASE_RESPAWN) + TIMER_W'(delay_q) * TIMER_W'(DELAY_STEP);

        always_ff @(posedge FrameClk) begin
            if (Reset) begin
                state_q <= SLOT_IDLE;
                tier_q  <= 2'd0;
                delay_q <= 3'd0;
                timer_q <= '0;
            end else begin
                state_q <= state_d;
                tier_q  <= tier_d;
                delay_q <= delay_d;
                timer_q <= timer_d;
            end
        end

        always_comb begin
            state_d = state_q;
            tier_d  = tier_q;
            delay_d = delay_q;
            timer_d = timer_q;
            if (!bus.SpawnEnable) begin
                state_d = SLOT_IDLE;
                tier_d  = 2'd0;
                delay_d = 3'd0;
                timer_d = '0;
            end else begin
                case (state_q)
                    SLOT_IDLE: begin
                        state_d = SLOT_ACTIVE;
                        tier_d  = roll_tier;
                    end
                    SLOT_ACTIVE: begin
                        if (granted[gi]) begin
                            state_d = SLOT_COOL;
                            delay_d = roll_r;
                            timer_d = '0;
                        end
                    end
                    SLOT_COOL: begin
                        // Timer starts at 0 on the grant edge, so the last count adds one frame.
                        if (timer_q == cool_last) begin
                            state_d = SLOT_ACTIVE;
                            tier_d  = roll_tier;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + 1'b1;
                        end
                    end
                    default: state_d = SLOT_IDLE;
                endcase
            end
        end

        always_comb begin
            is_active = (state_q == SLOT_ACTIVE);
        end

        assign active[gi]    = is_active;
        assign slot_tier[gi] = tier_q;
        assign p1_ovl[gi] = (p1_hx < SLOT_XR) && (SLOT_X < p1_hx + 10'd16) &&
                            (p1_hy < SLOT_YB) && (SPAWN_Y < p1_hy + 10'd16);
        assign p2_ovl[gi] = (p2_hx < SLOT_XR) && (SLOT_X < p2_hx + 10'd16) &&
                            (p2_hy < SLOT_YB) && (SPAWN_Y < p2_hy + 10'd16);
        assign pix_hit[gi] = is_active &&
                             (bus.DrawX >= SLOT_X) && (bus.DrawX < SLOT_XR) &&
                             (bus.DrawY >= SPAWN_Y) && (bus.DrawY < SLOT_YB);
        assign slot_px[gi] = 5'(bus.DrawX - SLOT_X);
        assign slot_py[gi] = 5'(bus.DrawY - SPAWN_Y);
    end

    // P2 picks first; P1 then picks among what P2 left behind.
    logic [NUM_SLOTS-1:0] p2_cand, p1_cand, p2_onehot, p1_onehot;
    logic                 p2_found, p1_found;
    logic [SLOT_W-1:0]    p2_idx, p1_idx;

    always_comb begin
        p2_cand  = active & p2_ovl & {NUM_SLOTS{!bus.P2Full}};
        p2_found = 1'b0;
        p2_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (p2_cand[i]) begin
                p2_found = 1'b1;
                p2_idx   = SLOT_W'(i);
            end
        end
        p2_onehot = p2_found ? (NUM_SLOTS'(1) << p2_idx) : '0;

        p1_cand  = active & p1_ovl & ~p2_onehot & {NUM_SLOTS{!bus.P1Full}};
        p1_found = 1'b0;
        p1_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (p1_cand[i]) begin
                p1_found = 1'b1;
                p1_idx   = SLOT_W'(i);
            end
        end
        p1_onehot = p1_found ? (NUM_SLOTS'(1) << p1_idx) : '0;
        granted   = p1_onehot | p2_onehot;
    end

    logic [1:0]        p1_collect_q, p1_collect_d, p2_collect_q, p2_collect_d;
    logic [SLOT_W-1:0] p1_slot_q, p1_slot_d, p2_slot_q, p2_slot_d;

    always_comb begin
        p1_collect_d = 2'd0;
        p1_slot_d    = '0;
        p2_collect_d = 2'd0;
        p2_slot_d    = '0;
        if (bus.SpawnEnable) begin
            if (p1_found) begin
                p1_collect_d = slot_tier[p1_idx];
                p1_slot_d    = p1_idx;
            end
            if (p2_found) begin
                p2_collect_d = slot_tier[p2_idx];
                p2_slot_d    = p2_idx;
            end
        end
    end

    always_ff @(posedge FrameClk) begin
        if (Reset) begin
            p1_collect_q <= 2'd0;
            p1_slot_q    <= '0;
            p2_collect_q <= 2'd0;
            p2_slot_q    <= '0;
        end else begin
            p1_collect_q <= p1_collect_d;
            p1_slot_q    <= p1_slot_d;
            p2_collect_q <= p2_collect_d;
            p2_slot_q    <= p2_slot_d;
        end
    end

    assign bus.P1Collect  = p1_collect_q;
    assign bus.P1Slot     = p1_slot_q;
    assign bus.P2Collect  = p2_collect_q;
    assign bus.P2Slot     = p2_slot_q;
    assign bus.ActiveMask = active;

    always_comb begin
        bus.MoneyPixel = 1'b0;
        bus.Tile       = 2'd0;
        bus.PixelX     = 5'd0;
        bus.PixelY     = 5'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pix_hit[i] && bus.SpawnEnable) begin
                bus.MoneyPixel = 1'b1;
                bus.Tile       = slot_tier[i];
                bus.PixelX     = slot_px[i];
                bus.PixelY     = slot_py[i];
            end
        end
    end
endmodule

// File: tb/tb_money_field.sv
// Directed and randomised frames for money_field, checked against a timestamp-based
// slot model that tracks absolute respawn frames rather than per-slot counters.
module tb_money_field;
    localparam int NS   = 4;
    localparam int BASE = 595;
    localparam int STEP = 60;
    localparam int SPY  = 436;
    localparam int MW   = 18;
    localparam int MH   = 18;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    money_field_if #(.NUM_SLOTS(NS)) bus ();
    money_field #(.NUM_SLOTS(NS)) dut (
        .FrameClk (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model: 0 = empty, 1 = bag on the floor, 2 = waiting for respawn frame.
    int m_state [NS];
    int m_tier  [NS];
    int m_resp  [NS];
    int frame = 0;
    int e_p1c, e_p1s, e_p2c, e_p2s;

    function automatic int roll(input int rnd, input int i);
        int r;
        r = (rnd ^ i) & 7;
        return ((r & 3) == 3) ? 3 : (r & 1) + 1;
    endfunction

    function automatic bit ovl(input int px, input int py, input int off, input int i);
        int sx, hx, hy;
        sx = 64 + 128 * i;
        hx = (px + off) & 1023;
        hy = (py + 16) & 1023;
        return (hx < ((sx + MW) & 1023)) && (sx < ((hx + 16) & 1023)) &&
               (hy < ((SPY + MH) & 1023)) && (SPY < ((hy + 16) & 1023));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int p1s, p2s, rnd;
        rnd = int'(bus.Random);
        e_p1c = 0; e_p1s = 0; e_p2c = 0; e_p2s = 0;
        frame++;
        if (rst || !bus.SpawnEnable) begin
            for (int i = 0; i < NS; i++) begin
                m_state[i] = 0;
                m_tier[i]  = 0;
            end
            return;
        end
        p2s = -1;
        p1s = -1;
        for (int i = 0; i < NS; i++)
            if (p2s < 0 && m_state[i] == 1 && !bus.P2Full &&
                ovl(int'(bus.P2X), int'(bus.P2Y), int'(bus.P2HbOffset), i)) p2s = i;
        for (int i = 0; i < NS; i++)
            if (p1s < 0 && i != p2s && m_state[i] == 1 && !bus.P1Full &&
                ovl(int'(bus.P1X), int'(bus.P1Y), int'(bus.P1HbOffset), i)) p1s = i;
        if (p1s >= 0) begin e_p1c = m_tier[p1s]; e_p1s = p1s; end
        if (p2s >= 0) begin e_p2c = m_tier[p2s]; e_p2s = p2s; end
        for (int i = 0; i < NS; i++) begin
            if (m_state[i] == 0) begin
                m_state[i] = 1;
                m_tier[i]  = roll(rnd, i);
            end else if (m_state[i] == 1 && (i == p1s || i == p2s)) begin
                m_state[i] = 2;
                m_resp[i]  = frame + BASE + ((rnd ^ i) & 7) * STEP + 1;
            end else if (m_state[i] == 2 && frame == m_resp[i]) begin
                m_state[i] = 1;
                m_tier[i]  = roll(rnd, i);
            end
        end
    endtask

    task automatic step(input string tag);
        int mask;
        model_edge();
        @(posedge clk);
        #1;
        mask = 0;
        for (int i = 0; i < NS; i++) if (m_state[i] == 1) mask |= (1 << i);
        chk({tag, ".p1_collect"}, 32'(bus.P1Collect), 32'(e_p1c));
        chk({tag, ".p1_slot"},    32'(bus.P1Slot),    32'(e_p1s));
        chk({tag, ".p2_collect"}, 32'(bus.P2Collect), 32'(e_p2c));
        chk({tag, ".p2_slot"},    32'(bus.P2Slot),    32'(e_p2s));
        chk({tag, ".active_mask"}, 32'(bus.ActiveMask), 32'(mask));
    endtask

    task automatic render(input string tag, input int dx, input int dy);
        int hit, sx;
        bus.DrawX = 10'(dx);
        bus.DrawY = 10'(dy);
        #1;
        hit = -1;
        for (int i = NS - 1; i >= 0; i--) begin
            sx = 64 + 128 * i;
            if (bus.SpawnEnable && m_state[i] == 1 && dx >= sx && dx < sx + MW &&
                dy >= SPY && dy < SPY + MH) hit = i;
        end
        chk({tag, ".money_pixel"}, 32'(bus.MoneyPixel), (hit >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".tile"},   32'(bus.Tile),   (hit >= 0) ? 32'(m_tier[hit]) : 32'd0);
        chk({tag, ".pixel_x"}, 32'(bus.PixelX), (hit >= 0) ? 32'(dx - (64 + 128 * hit)) : 32'd0);
        chk({tag, ".pixel_y"}, 32'(bus.PixelY), (hit >= 0) ? 32'(dy - SPY) : 32'd0);
    endtask

    task automatic players_away();
        bus.P1X = 10'd0; bus.P1Y = 10'd0; bus.P1HbOffset = 5'd0;
        bus.P2X = 10'd0; bus.P2Y = 10'd0; bus.P2HbOffset = 5'd0;
    endtask

    initial begin
        int k;
        bit found;
        for (int i = 0; i < NS; i++) begin m_state[i] = 0; m_tier[i] = 0; m_resp[i] = 0; end
        rst = 1'b1;
        bus.SpawnEnable = 1'b0;
        bus.P1Full = 1'b0; bus.P2Full = 1'b0;
        bus.Random = 3'd0;
        bus.DrawX = 10'd0; bus.DrawY = 10'd0;
        players_away();

        step("reset0");
        step("reset1");
        chk("reset.p1_collect_zero", 32'(bus.P1Collect), 32'd0);

        // Spawn all slots with Random=011.
        rst = 1'b0;
        bus.SpawnEnable = 1'b1;
        bus.Random = 3'b011;
        step("spawn");
        chk("spawn.mask_all", 32'(bus.ActiveMask), 32'hF);
        render("r_slot0_tl", 64, 436);
        chk("spawn.slot0_gold", 32'(bus.Tile), 32'd3);
        render("r_slot1_br", 192 + 17, 436 + 17);
        render("r_slot1_right_out", 192 + 18, 440);
        render("r_above_out", 70, 435);

        // P1 grabs slot 0.
        bus.P1X = 10'd64; bus.P1Y = 10'd420;
        step("p1_slot0");
        chk("p1_slot0.tier3", 32'(bus.P1Collect), 32'd3);
        chk("p1_slot0.mask0", 32'(bus.ActiveMask[0]), 32'd0);
        step("p1_slot0_stand");
        render("r_slot0_cool", 70, 440);

        // Both players on slot 1: P2 wins.
        bus.P1X = 10'd192; bus.P2X = 10'd192; bus.P2Y = 10'd420;
        step("both_slot1");
        chk("both_slot1.p2_slot", 32'(bus.P2Slot), 32'd1);
        chk("both_slot1.p1_none", 32'(bus.P1Collect), 32'd0);

        // Drop enable for a frame to refill every slot.
        players_away();
        bus.SpawnEnable = 1'b0;
        step("se_low");
        render("r_se_low", 200, 440);
        bus.SpawnEnable = 1'b1;
        step("se_high");
        chk("se_high.mask_all", 32'(bus.ActiveMask), 32'hF);

        // Full P2 does not block P1.
        bus.P1X = 10'd192; bus.P1Y = 10'd420;
        bus.P2X = 10'd192; bus.P2Y = 10'd420; bus.P2Full = 1'b1;
        step("p2full");
        chk("p2full.p1_slot", 32'(bus.P1Slot), 32'd1);
        chk("p2full.p1_got", 32'(bus.P1Collect != 2'd0), 32'd1);
        chk("p2full.p2_none", 32'(bus.P2Collect), 32'd0);
        bus.P2Full = 1'b0;
        players_away();

        // Slot 2 cooldown length with Random=0 (delay 2).
        bus.Random = 3'd0;
        bus.P1X = 10'd320; bus.P1Y = 10'd420;
        step("grant2");
        chk("grant2.slot", 32'(bus.P1Slot), 32'd2);
        players_away();
        k = 0;
        found = 1'b0;
        for (int n = 1; n <= 800 && !found; n++) begin
            bus.Random = 3'($urandom_range(0, 7));
            step("cool2");
            if (bus.ActiveMask[2]) begin
                found = 1'b1;
                k = n;
            end
        end
        chk("slot2_respawn_frames", 32'(k), 32'd716);

        // Touching edges do not collide; one pixel of overlap does.
        bus.P1X = 10'd304; bus.P1Y = 10'd420; bus.P1HbOffset = 5'd0;
        step("edge_touch");
        chk("edge_touch.none", 32'(bus.P1Collect), 32'd0);
        bus.P1X = 10'd305;
        step("edge_overlap");
        chk("edge_overlap.slot", 32'(bus.P1Slot), 32'd2);
        chk("edge_overlap.got", 32'(bus.P1Collect != 2'd0), 32'd1);
        players_away();

        // Enable low mid-cooldown, then everything respawns at once.
        bus.SpawnEnable = 1'b0;
        step("mid_cool_low");
        bus.SpawnEnable = 1'b1;
        step("mid_cool_high");
        chk("mid_cool_high.mask_all", 32'(bus.ActiveMask), 32'hF);

        // Reset in the same frame as a grant suppresses everything.
        bus.P1X = 10'd64; bus.P1Y = 10'd420;
        rst = 1'b1;
        step("rst_grant");
        chk("rst_grant.p1_zero", 32'(bus.P1Collect), 32'd0);
        chk("rst_grant.mask_zero", 32'(bus.ActiveMask), 32'd0);
        rst = 1'b0;
        players_away();

        // Random play near the bank row.
        for (int n = 0; n < 400; n++) begin
            bus.Random      = 3'($urandom_range(0, 7));
            bus.P1Full      = ($urandom_range(0, 3) == 0);
            bus.P2Full      = ($urandom_range(0, 3) == 0);
            bus.P1X         = 10'($urandom_range(0, 560));
            bus.P1Y         = 10'($urandom_range(395, 445));
            bus.P1HbOffset  = 5'($urandom_range(0, 31));
            bus.P2X         = 10'($urandom_range(0, 560));
            bus.P2Y         = 10'($urandom_range(395, 445));
            bus.P2HbOffset  = 5'($urandom_range(0, 31));
            bus.SpawnEnable = ($urandom_range(0, 39) != 0);
            rst             = ($urandom_range(0, 99) == 0);
            step("rand");
            render("r_rand", int'($urandom_range(50, 470)), int'($urandom_range(430, 460)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
